uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmit line between NUM_REQ byte requesters using round-robin arbitration. Serialises the granted byte as 8N1: start bit, 8 data bits LSB first, stop bit. Bit timing comes from the oversampled baud_tick pulse produced by the team's baud-rate generator (8 ticks per bit at 115200 baud, 100 MHz clock). It sits between the application-side message sources and the physical tx pin.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
OVERSAMPLE, 8, baud_tick pulses per bit period; must match the generator's oversample factor

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
baud_tick  input  1  one-clk pulse, OVERSAMPLE per bit period
req  input  NUM_REQ  per-requester send request, level; held until ack
req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i]; stable while req[i] is high and ack[i] is low
ack  output  NUM_REQ  one-hot, one-clk pulse: byte of requester i captured
done  output  NUM_REQ  one-hot, one-clk pulse: frame of requester i fully sent (end of stop bit)
tx  output  1  serial line, registered, idle high
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: tx=1, busy=0, ack=0, done=0, state=IDLE, rr_ptr=NUM_REQ-1 so req[0] has first priority. Also clears tick_cnt, bit_idx, owner and shift register.
- All outputs are registered.
- Reset mid-frame: on the next edge tx=1 and state=IDLE. No done pulse is issued, and the interrupted byte is dropped.
- FSM states: IDLE, START, DATA, STOP. The optional PARITY state is described below.
- IDLE, when req != 0:
  - Winner = first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - On the same edge: latch req_data[winner], set owner=winner and rr_ptr=winner, pulse ack[winner] for one cycle, go to START.
  - baud_tick is ignored while in IDLE.
- Bit timing:
  - tick_cnt clears on entry to every bit state.
  - Each baud_tick increments tick_cnt.
  - A baud_tick seen while tick_cnt==OVERSAMPLE-1 ends the bit.
  - The start bit therefore lasts OVERSAMPLE ticks counted from the first tick after entry. Its phase is not aligned to the tick grid.
- tx is driven on the edge that enters each state:
  - START: tx=0.
  - DATA: tx=shift[0]. bit_idx runs 0..7 and the register shifts right at the end of each bit. Leave DATA after bit_idx==7 ends.
  - STOP: tx=1. At the end of the bit, pulse done[owner] for one cycle and return to IDLE.
- Back-to-back frames: at least one clk in IDLE separates them. Arbitration happens only in IDLE, so the next ack can occur no earlier than 1 clk after done.
- req changes during a frame have no effect on that frame. A requester dropping req before ack forfeits the request with no ack.
- Requester i may reassert req on the clk after ack[i]. Round-robin then serves other pending requesters first.
- With NUM_REQ=1 the block degenerates to a plain transmitter: ack follows each req in IDLE.

Optional Feature:
- Macro: UART_TX_ARB_PARITY_EN.
- Defined: state PARITY is inserted between DATA and STOP. It drives tx = even parity (XOR of the 8 captured data bits) for OVERSAMPLE ticks. Frame = 11 bit periods.
- Undefined: no PARITY state and no parity logic. Frame = 10 bit periods, 8N1.

Test Plan:
- Single request: NUM_REQ=2, baud_tick every 108 clk, req[0]=1, data 0x55. Expect ack=01 one clk later, then tx = 0,1,0,1,0,1,0,1,0,1. Each bit is 8 ticks (864 clk ±108 on the start bit). done=01 after the stop bit, busy low 1 clk after done.
- Simultaneous requests from reset: req=11, data0=0xA5, data1=0x3C. Frame 0xA5 is sent first (ack=01), then 0x3C (ack=10). Exactly one done pulse per frame, in the same order.
- Fairness: req=11 held continuously and reasserted after every ack. Grant order over 6 frames must be 0,1,0,1,0,1, with no starvation.
- Reset mid-DATA: assert reset for 1 clk during bit_idx=3. Expect tx=1, busy=0, done=00 on the next edge. Then req[1]=1 yields a clean frame with ack=10.
- Sparse/absent ticks: hold baud_tick=0 for 1000 clk after ack. Expect tx stays 0 and state stays START; the frame resumes correctly once ticks restart.
- Parity build (UART_TX_ARB_PARITY_EN defined): data 0x07. Expect the parity bit=1 between data bit 7 and stop, and a frame of 88 ticks.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle for uart_tx_arbiter: per-requester request level, byte lanes and one-hot ack/done pulses.
// Latency: none (wires only); ack/done are registered pulses produced by the arbiter.
// Backpressure: a requester holds req/req_data until its ack pulse; there is no other stall path.
// Ports: req[NUM_REQ], req_data[8*NUM_REQ] (byte i at [8i+7:8i]), ack[NUM_REQ], done[NUM_REQ].
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   done;

  // master: the message sources; slave: the arbiter/transmitter
  modport master (output req, output req_data, input ack, input done);
  modport slave  (input req, input req_data, output ack, output done);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART tx line between NUM_REQ byte sources; bit timing from baud_tick_i.
// Latency: ack 1 clk after req seen in IDLE; frame = 10 bit periods (11 with parity), done at end of stop bit.
// Backpressure: requests wait (req held) while a frame is in flight; arbitration only happens in IDLE.
// Ports: clk_i, reset_i (sync, active-high), baud_tick_i (OVERSAMPLE pulses per bit),
//        req_if (slave modport: req/req_data in, ack/done out), tx_o (registered, idle high), busy_o.
// Optional: define UART_TX_ARB_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int OVERSAMPLE = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             baud_tick_i,
  uart_tx_arbiter_if.slave req_if,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_ARB_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [TICK_W-1:0]  tick_cnt_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic               tx_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] done_q;
`ifdef UART_TX_ARB_PARITY_EN
  logic               parity_q;
`endif

  logic               win_vld_d;
  logic [IDX_W-1:0]   win_idx_d;
  logic [IDX_W-1:0]   scan_idx;
  logic               bit_end;

  // Scan from rr_ptr+NUM_REQ down to rr_ptr+1 so the last hit (closest to rr_ptr+1) wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    scan_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_if.req[scan_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = scan_idx;
      end
    end
  end

  assign bit_end = baud_tick_i && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q    <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
`ifdef UART_TX_ARB_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      ack_q  <= '0;
      done_q <= '0;

      // Per-bit tick counter; every state transition below happens on bit_end, which wraps it to 0.
      if (state_q != IDLE && baud_tick_i) begin
        tick_cnt_q <= bit_end ? '0 : tick_cnt_q + TICK_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            shift_q          <= req_if.req_data[8*win_idx_d +: 8];
`ifdef UART_TX_ARB_PARITY_EN
            parity_q         <= ^req_if.req_data[8*win_idx_d +: 8];
`endif
            owner_q          <= win_idx_d;
            rr_ptr_q         <= win_idx_d;
            ack_q[win_idx_d] <= 1'b1;
            tick_cnt_q       <= '0;
            tx_q             <= 1'b0;
            busy_q           <= 1'b1;
            state_q          <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_ARB_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            done_q[owner_q] <= 1'b1;
            busy_q          <= 1'b0;
            state_q         <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign req_if.ack  = ack_q;
  assign req_if.done = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NR = 2;
  localparam int OS = 8;
`ifdef UART_TX_ARB_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic baud_tick = 1'b0;
  logic tx, busy;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .OVERSAMPLE(OS)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .baud_tick_i(baud_tick),
    .req_if     (bus),
    .tx_o       (tx),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: frame as a bit array indexed by ticks since ack
  function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
    logic [NB-1:0] f;
    f = '0;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_ARB_PARITY_EN
    f[9]   = ^d;
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  bit            model_ok = 0;
  bit            m_active;
  int            m_ticks, m_owner, m_rr;
  logic [NB-1:0] m_frame;
  logic          exp_tx, exp_busy;
  logic [NR-1:0] exp_ack, exp_done;
  int            ack_order[$];
  int            done_order[$];

  always @(posedge clk) begin
    int w;
    if (reset) begin
      model_ok = 1;
      m_active = 0; m_ticks = 0; m_owner = 0; m_rr = NR - 1;
      exp_tx = 1'b1; exp_busy = 1'b0; exp_ack = '0; exp_done = '0;
    end else if (model_ok) begin
      exp_ack = '0;
      exp_done = '0;
      if (!m_active) begin
        w = -1;
        for (int k = 1; k <= NR; k++)
          if (w < 0 && bus.req[(m_rr + k) % NR]) w = (m_rr + k) % NR;
        if (w >= 0) begin
          m_owner = w; m_rr = w; m_ticks = 0; m_active = 1;
          m_frame = frame_of(bus.req_data[8*w +: 8]);
          exp_ack[w] = 1'b1; exp_tx = 1'b0; exp_busy = 1'b1;
        end
      end else if (baud_tick) begin
        m_ticks++;
        if (m_ticks == NB * OS) begin
          exp_done[m_owner] = 1'b1; m_active = 0; exp_busy = 1'b0; exp_tx = 1'b1;
        end else begin
          exp_tx = m_frame[m_ticks / OS];
        end
      end
    end
  end

  // compare + record DUT grant/done order
  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      check("tx", tx, exp_tx);
      check("busy", busy, exp_busy);
      check("ack", bus.ack, exp_ack);
      check("done", bus.done, exp_done);
    end
    for (int i = 0; i < NR; i++) begin
      if (bus.ack[i]) ack_order.push_back(i);
      if (bus.done[i]) done_order.push_back(i);
    end
  end

  // ---------------- stimulus
  bit         tick_en = 0;
  int         tick_period = 0;   // 0 => random ticks
  int         tick_ph = 0;
  bit         rnd_data = 0;
  bit         drop_en = 0;
  int         remaining[NR];
  logic [7:0] fixed_data[NR];

  task automatic cyc();
    @(negedge clk);
    if (!tick_en) baud_tick = 1'b0;
    else if (tick_period == 0) baud_tick = ($urandom_range(2, 0) == 0);
    else begin
      tick_ph++;
      if (tick_ph >= tick_period) tick_ph = 0;
      baud_tick = (tick_ph == 0);
    end
    for (int i = 0; i < NR; i++) begin
      if (bus.ack[i]) begin
        bus.req[i] = 1'b0;
        if (remaining[i] > 0) remaining[i]--;
      end else if (drop_en && bus.req[i] && $urandom_range(15, 0) == 0) begin
        bus.req[i] = 1'b0;
        if (remaining[i] > 0) remaining[i]--;
      end else if (!bus.req[i] && remaining[i] > 0) begin
        bus.req[i] = 1'b1;
        bus.req_data[8*i +: 8] = rnd_data ? 8'($urandom) : fixed_data[i];
      end
    end
  endtask

  task automatic wait_ack(input int i, input string nm);
    int c = 0;
    while (bus.ack == '0 && c < 40000) begin cyc(); c++; end
    check(nm, bus.ack, 32'(1) << i);
  endtask

  task automatic wait_done(input int i, input string nm);
    int c = 0;
    while (bus.done == '0 && c < 40000) begin cyc(); c++; end
    check(nm, bus.done, 32'(1) << i);
  endtask

  // Count ticks after ack and sample tx mid-bit; stops at done or after stop_at ticks.
  task automatic track_frame(input int stop_at, output int n, output logic [NB-1:0] vec);
    bit t;
    n = 0;
    vec = '0;
    for (int c = 0; c < 40000; c++) begin
      t = baud_tick;
      cyc();
      if (t) begin
        n++;
        if (n % OS == OS / 2) vec[n / OS] = tx;
      end
      if (bus.done != '0 || n == stop_at) break;
    end
  endtask

  task automatic do_reset(input int len);
    reset = 1'b1;
    for (int c = 0; c < len; c++) cyc();
    reset = 1'b0;
  endtask

  initial begin
    int            n, bad, c;
    logic [NB-1:0] vec;
    bus.req = '0;
    bus.req_data = '0;
    for (int i = 0; i < NR; i++) begin remaining[i] = 0; fixed_data[i] = 8'h00; end

    // pin the model's frame builder
`ifdef UART_TX_ARB_PARITY_EN
    check("model_frame_A5", frame_of(8'hA5), 32'b10101001010);
    check("model_frame_07", frame_of(8'h07), 32'b11000001110);
`else
    check("model_frame_A5", frame_of(8'hA5), 32'b1101001010);
    check("model_frame_55", frame_of(8'h55), 32'b1010101010);
`endif

    // reset state
    do_reset(3);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_ack", bus.ack, 0);
    check("reset_done", bus.done, 0);

    // single request, baud_tick every 108 clk
    tick_en = 1; tick_period = 108; tick_ph = 0;
`ifdef UART_TX_ARB_PARITY_EN
    fixed_data[0] = 8'h07;
`else
    fixed_data[0] = 8'h55;
`endif
    remaining[0] = 1;
    wait_ack(0, "single_ack");
    track_frame(-1, n, vec);
    check("single_ticks", n, NB * OS);
`ifdef UART_TX_ARB_PARITY_EN
    check("single_bits", vec, 32'b11000001110);
`else
    check("single_bits", vec, 32'b1010101010);
`endif
    check("single_done", bus.done, 2'b01);
    cyc();
    check("single_busy_after", busy, 0);

    // simultaneous requests from reset
    tick_period = 3;
    do_reset(2);
    ack_order.delete(); done_order.delete();
    fixed_data[0] = 8'hA5; fixed_data[1] = 8'h3C;
    remaining[0] = 1; remaining[1] = 1;
    wait_ack(0, "simul_ack0");
    wait_done(0, "simul_done0");
    wait_ack(1, "simul_ack1");
    wait_done(1, "simul_done1");
    cyc();
    check("simul_acks", ack_order.size(), 2);
    check("simul_dones", done_order.size(), 2);

    // fairness with continuous reassertion
    tick_period = 0; rnd_data = 1;
    ack_order.delete(); done_order.delete();
    remaining[0] = 3; remaining[1] = 3;
    c = 0;
    while (done_order.size() < 6 && c < 20000) begin cyc(); c++; end
    check("fair_frames", done_order.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < ack_order.size()) check($sformatf("fair_grant%0d", k), ack_order[k], k % 2);
      else check($sformatf("fair_grant%0d", k), 32'hFFFFFFFF, k % 2);
    end

    // reset in the middle of data bit 3
    tick_period = 2;
    remaining[0] = 1;
    wait_ack(0, "mid_ack");
    track_frame(35, n, vec);
    check("mid_reached", n, 35);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", bus.done, 0);
    remaining[1] = 1;
    wait_ack(1, "mid_after_ack");
    wait_done(1, "mid_after_done");

    // ticks absent for 1000 clk after ack
    remaining[0] = 1;
    wait_ack(0, "sparse_ack");
    tick_en = 0; baud_tick = 1'b0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc();
      if (tx !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("sparse_hold", bad, 0);
    tick_en = 1;
    wait_done(0, "sparse_done");

    // randomized traffic with forfeits
    tick_period = 0; drop_en = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NR; i++) remaining[i] = $urandom_range(3, 1);
      c = 0;
      while ((remaining[0] + remaining[1] != 0 || bus.req != '0 || busy) && c < 20000) begin
        cyc(); c++;
      end
      check("rand_drained", busy, 0);
    end
    drop_en = 0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // simple-order literals for the simultaneous test are checked here once both frames are recorded
  initial begin
    int c;
    c = 0;
    // wait for the simultaneous test window: first time two acks recorded with data A5/3C loaded
    while (!(fixed_data[1] == 8'h3C && ack_order.size() >= 2 && done_order.size() >= 2) && c < 90000) begin
      @(posedge clk); c++;
    end
    #2;
    if (c < 90000) begin
      check("simul_order_a0", ack_order[0], 0);
      check("simul_order_a1", ack_order[1], 1);
      check("simul_order_d0", done_order[0], 0);
      check("simul_order_d1", done_order[1], 1);
    end else begin
      check("simul_order_seen", 0, 1);
    end
  end
endmodule
